spi_slave: RTL and testbench

- SPI responder: the far-end device that the existing SPI master talks to over sclk/ss/mosi/miso.
- Runs entirely on the local global_clk and oversamples the master's sclk and ss through synchronizers.
- Mode 0 (CPOL=0, CPHA=0), MSB first.
- Shifts out a preloaded transmit byte while capturing the master's byte, then presents the received word with a one-cycle valid strobe.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_slave.sv | 165 ++++++++++++++++
 tb/tb_spi_slave.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI constants, default word width and responder state encoding
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 8;

    // Mode 0: sclk idles low, data sampled on the leading (rising) edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall detection taken only from flops
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the pin through the chain and keep a copy of the last stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI responder oversampling sclk/ss/mosi on the local clock
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  global_clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  underrun
);

    localparam int            CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic                   w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
    logic                   w_sample, w_shift, w_mosi, w_load_ok, w_consume;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    spi_state_t             r_state, w_state_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0]  r_rx_shift, w_rx_shift_nxt;
    logic [DATA_WIDTH-1:0]  r_tx_shift, w_tx_shift_nxt;
    logic [DATA_WIDTH-1:0]  r_rx_data, w_rx_data_nxt;
    logic [DATA_WIDTH-1:0]  r_tx_buf;
    logic                   r_tx_ready, r_rx_valid, w_rx_valid_nxt;
    logic                   r_underrun, w_underrun_nxt, r_miso, w_miso_nxt;
    logic                   r_wrap, w_wrap_nxt;
    logic                   r_pend, w_pend_nxt, r_pend_empty, w_pend_empty_nxt;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sclk_sync (
        .clk     (global_clk),
        .rst_n   (reset),
        .i_async (sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk     (global_clk),
        .rst_n   (reset),
        .i_async (ss),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    // mosi only needs the level; it is read when the sample edge is seen
    always_ff @(posedge global_clk or negedge reset) begin
        if (!reset) r_mosi_sync <= '0;
        else        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
    end

    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sample  = (SPI_CPOL == SPI_CPHA) ? w_sclk_rise : w_sclk_fall;
    assign w_shift   = (SPI_CPOL == SPI_CPHA) ? w_sclk_fall : w_sclk_rise;
    assign w_load_ok = tx_load & r_tx_ready;

    // Next-state and datapath: the reload at a word boundary only peeks the buffer;
    // the buffer is committed (or underrun flagged) on the first sample edge of that
    // word, so a trailing sclk fall before ss rises never eats an unsent buffer.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_rx_shift_nxt   = r_rx_shift;
        w_tx_shift_nxt   = r_tx_shift;
        w_rx_data_nxt    = r_rx_data;
        w_rx_valid_nxt   = 1'b0;
        w_underrun_nxt   = 1'b0;
        w_wrap_nxt       = r_wrap;
        w_pend_nxt       = r_pend;
        w_pend_empty_nxt = r_pend_empty;
        w_consume        = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_ss_fall) begin
                w_state_nxt    = ST_ACTIVE;
                w_cnt_nxt      = '0;
                w_wrap_nxt     = 1'b0;
                w_pend_nxt     = 1'b0;
                w_tx_shift_nxt = r_tx_ready ? '0 : r_tx_buf;
                w_consume      = ~r_tx_ready;
                w_underrun_nxt = r_tx_ready;
            end
        end else if (w_ss_rise) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_wrap_nxt  = 1'b0;
            w_pend_nxt  = 1'b0;
        end else begin
            if (w_sample) begin
                w_rx_shift_nxt = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                w_cnt_nxt      = (r_cnt == LAST_BIT) ? '0 : r_cnt + CW'(1);
                if (r_cnt == LAST_BIT) begin
                    w_rx_data_nxt  = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                    w_rx_valid_nxt = 1'b1;
                    w_wrap_nxt     = 1'b1;
                end
                if (r_pend) begin
                    w_pend_nxt     = 1'b0;
                    w_consume      = ~r_pend_empty;
                    w_underrun_nxt = r_pend_empty;
                end
            end
            if (w_shift) begin
                if (r_wrap) begin
                    w_tx_shift_nxt   = r_tx_ready ? '0 : r_tx_buf;
                    w_pend_nxt       = 1'b1;
                    w_pend_empty_nxt = r_tx_ready;
                    w_wrap_nxt       = 1'b0;
                end else begin
                    w_tx_shift_nxt = r_tx_shift << 1;
                end
            end
        end
        w_miso_nxt = (w_state_nxt == ST_ACTIVE) & w_tx_shift_nxt[DATA_WIDTH-1];
    end

    // State, shift registers, transmit buffer and output strobes
    always_ff @(posedge global_clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_rx_shift   <= '0;
            r_tx_shift   <= '0;
            r_rx_data    <= '0;
            r_tx_buf     <= '0;
            r_tx_ready   <= 1'b1;
            r_rx_valid   <= 1'b0;
            r_underrun   <= 1'b0;
            r_miso       <= 1'b0;
            r_wrap       <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_empty <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rx_shift   <= w_rx_shift_nxt;
            r_tx_shift   <= w_tx_shift_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_tx_buf     <= w_load_ok ? tx_data : r_tx_buf;
            r_tx_ready   <= w_consume ? 1'b1 : (w_load_ok ? 1'b0 : r_tx_ready);
            r_rx_valid   <= w_rx_valid_nxt;
            r_underrun   <= w_underrun_nxt;
            r_miso       <= w_miso_nxt;
            r_wrap       <= w_wrap_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_empty <= w_pend_empty_nxt;
        end
    end

    assign miso     = r_miso;
    assign tx_ready = r_tx_ready;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: mode-0 master model driving spi_slave with an rx/miso scoreboard
module tb_spi_slave;

    localparam int SYNC = 2;

    logic       global_clk = 1'b0;
    logic       reset      = 1'b0;
    logic       sclk       = 1'b0;
    logic       ss         = 1'b1;
    logic       mosi       = 1'b0;
    logic       tx_load    = 1'b0;
    logic [7:0] tx_data    = 8'h00;
    logic       miso, tx_ready, rx_valid, underrun;
    logic [7:0] rx_data;

    int         checks  = 0;
    int         errors  = 0;
    int         rxv_cnt = 0;
    int         und_cnt = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC)) dut (
        .global_clk (global_clk),
        .reset      (reset),
        .sclk       (sclk),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .underrun   (underrun)
    );

    always #5 global_clk = ~global_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Received words are popped from the scoreboard as the DUT strobes them
    always @(negedge global_clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            if (exp_rx.size() == 0) check("rx_unexpected", exp_rx.size(), 1);
            else check("rx_data", rx_data, exp_rx.pop_front());
        end
        if (underrun) und_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge global_clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
    endtask

    task automatic ss_low();
        ss = 1'b0;
        tick(8);
    endtask

    task automatic ss_high();
        tick(8);
        ss = 1'b1;
        tick(8);
    endtask

    // One full word at sclk = global_clk/16; miso captured on each rising edge
    task automatic word(input logic [7:0] m);
        logic [7:0] got;
        got = 8'h00;
        exp_rx.push_back(m);
        for (int i = 7; i >= 0; i--) begin
            mosi = m[i];
            tick(8);
            got[i] = miso;
            sclk = 1'b1;
            tick(8);
            sclk = 1'b0;
        end
        if (exp_miso.size() == 0) check("miso_unexpected", exp_miso.size(), 1);
        else check("miso_word", got, exp_miso.pop_front());
    endtask

    task automatic partial(input logic [7:0] m, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = m[i];
            tick(8);
            sclk = 1'b1;
            tick(8);
            sclk = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tick(3);
        check("rst_miso", miso, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b1;
        tick(3);

        load(8'h0F);
        check("single_tx_ready_full", tx_ready, 0);
        exp_miso.push_back(8'h0F);
        ss_low();
        check("single_tx_ready_empty", tx_ready, 1);
        word(8'hF0);
        ss_high();
        check("single_rxv_count", rxv_cnt, 1);
        check("single_underrun", und_cnt, 0);

        load(8'hA5);
        exp_miso.push_back(8'hA5);
        exp_miso.push_back(8'h5A);
        ss_low();
        fork
            begin
                word(8'h3C);
                word(8'hC3);
            end
            begin
                tick(40);
                load(8'h5A);
            end
        join
        ss_high();
        check("burst_rxv_count", rxv_cnt, 3);
        check("burst_underrun", und_cnt, 0);
        check("burst_tx_ready", tx_ready, 1);

        exp_miso.push_back(8'h00);
        ss_low();
        check("underrun_at_ss_fall", und_cnt, 1);
        word(8'h81);
        ss_high();
        check("underrun_once", und_cnt, 1);
        check("underrun_rxv_count", rxv_cnt, 4);

        load(8'hFF);
        ss_low();
        partial(8'h33, 5);
        tick(8);
        check("abort_miso_before", miso, 1);
        ss = 1'b1;
        tick(SYNC + 2);
        check("abort_miso_zero", miso, 0);
        tick(8);
        check("abort_no_rxv", rxv_cnt, 4);
        check("abort_rx_hold", rx_data, 8'h81);
        exp_miso.push_back(8'h00);
        ss_low();
        word(8'h77);
        ss_high();
        check("abort_next_rxv", rxv_cnt, 5);

        load(8'h3C);
        ss_low();
        partial(8'hAA, 4);
        #3;
        reset = 1'b0;
        #1;
        check("areset_miso", miso, 0);
        check("areset_tx_ready", tx_ready, 1);
        check("areset_rx_data", rx_data, 0);
        check("areset_rx_valid", rx_valid, 0);
        check("areset_underrun", underrun, 0);
        sclk = 1'b0;
        ss = 1'b1;
        mosi = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(3);
        exp_miso.push_back(8'h00);
        ss_low();
        word(8'hFF);
        ss_high();
        check("areset_rx_ff", rx_data, 8'hFF);
        check("areset_rxv_count", rxv_cnt, 6);

        tx_data = 8'h11;
        tx_load = 1'b1;
        tick(1);
        tx_data = 8'h22;
        tick(1);
        tx_load = 1'b0;
        check("ignored_tx_ready", tx_ready, 0);
        exp_miso.push_back(8'h11);
        ss_low();
        word(8'h5E);
        ss_high();
        check("ignored_rxv_count", rxv_cnt, 7);

        tick(10);
        check("sb_rx_empty", exp_rx.size(), 0);
        check("sb_miso_empty", exp_miso.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
